// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nand3_bist_ctrl_if.sv
// Stimulus/response bundle between the nand3 BIST controller and the cells under test.
// master = BIST controller, slave = environment (cells plus whoever starts the run).
interface gf180mcu_fd_sc_mcu9t5v0__nand3_bist_ctrl_if #(
  parameter int unsigned NUM_DUT = 4,
  parameter int unsigned ERR_W   = 8
);
  logic               START;
  logic               A1;
  logic               A2;
  logic               A3;
  logic [NUM_DUT-1:0] ZN;
  logic               BUSY;
  logic               DONE;
  logic               PASS;
  logic [NUM_DUT-1:0] FAIL_MAP;
  logic [ERR_W-1:0]   ERR_CNT;

  modport master (
    input  START, ZN,
    output A1, A2, A3, BUSY, DONE, PASS, FAIL_MAP, ERR_CNT
  );

  modport slave (
    output START, ZN,
    input  A1, A2, A3, BUSY, DONE, PASS, FAIL_MAP, ERR_CNT
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nand3_bist_ctrl.sv
// Built-in self-test for NUM_DUT parallel nand3 cells: walks all 8 input vectors,
// holds each for SETTLE_CYCLES, then compares every ZN against ~(A1&A2&A3).
module gf180mcu_fd_sc_mcu9t5v0__nand3_bist_ctrl #(
  parameter int unsigned NUM_DUT       = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8
) (
  input  logic CLK,
  input  logic RST,
  gf180mcu_fd_sc_mcu9t5v0__nand3_bist_ctrl_if.master bist
);

  localparam int unsigned CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned PW = $clog2(NUM_DUT + 1);
  localparam int unsigned SW = ERR_W + PW;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         vec_q, vec_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_DUT-1:0] fail_q, fail_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               exp_zn;
  logic [NUM_DUT-1:0] mism;
  logic [PW-1:0]      pop;
  logic [SW-1:0]      sum;
  logic [ERR_W-1:0]   err_sat;

  // Per-instance mismatch, popcount and saturating error accumulation
  always_comb begin
    exp_zn = ~(vec_q[0] & vec_q[1] & vec_q[2]);
    mism   = '0;
    pop    = '0;
    for (int unsigned i = 0; i < NUM_DUT; i++) begin
      // Case inequality makes an X/Z ZN count as a failure in simulation
      mism[i] = (bist.ZN[i] !== exp_zn);
      pop     = pop + PW'(mism[i]);
    end
    sum     = SW'(err_q) + SW'(pop);
    err_sat = (sum > SW'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
  end

  // Next-state logic for the vector walk
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bist.START) begin
          state_d = ST_SETTLE;
          vec_d   = '0;
          cnt_d   = CNT_LOAD;
          fail_d  = '0;
          err_d   = '0;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        fail_d = fail_q | mism;
        err_d  = err_sat;
        if (vec_q == 3'd7) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset aborts any run in progress
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign bist.A1       = vec_q[0];
  assign bist.A2       = vec_q[1];
  assign bist.A3       = vec_q[2];
  assign bist.BUSY     = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign bist.DONE     = (state_q == ST_DONE);
  assign bist.PASS     = (state_q == ST_DONE) && (fail_q == '0);
  assign bist.FAIL_MAP = fail_q;
  assign bist.ERR_CNT  = err_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nand3_bist_ctrl.sv
// Directed bench for the nand3 BIST controller: fault-injected nand3 models,
// a table of fault patterns with expected results, plus reset/START corner sequences.
module tb_gf180mcu_fd_sc_mcu9t5v0__nand3_bist_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] st0, st1;   // stuck-at-0 / stuck-at-1 masks for instance A cells

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__nand3_bist_ctrl_if #(.NUM_DUT(4), .ERR_W(8)) ifa ();
  gf180mcu_fd_sc_mcu9t5v0__nand3_bist_ctrl_if #(.NUM_DUT(4), .ERR_W(2)) ifb ();

  gf180mcu_fd_sc_mcu9t5v0__nand3_bist_ctrl #(
    .NUM_DUT(4), .SETTLE_CYCLES(2), .ERR_W(8)
  ) dut_a (
    .CLK(clk), .RST(rst), .bist(ifa.master)
  );

  gf180mcu_fd_sc_mcu9t5v0__nand3_bist_ctrl #(
    .NUM_DUT(4), .SETTLE_CYCLES(1), .ERR_W(2)
  ) dut_b (
    .CLK(clk), .RST(rst), .bist(ifb.master)
  );

  // Four nand3 models with injectable stuck-at faults
  logic good_zn;
  assign good_zn = ~(ifa.A1 & ifa.A2 & ifa.A3);
  assign ifa.ZN  = ({4{good_zn}} | st1) & ~st0;
  // Instance B: every cell stuck-at-0
  assign ifb.ZN  = 4'b0000;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] s0;
    logic [3:0] s1;
    logic [7:0] e_err;
    logic [3:0] e_fail;
    logic       e_pass;
  } vec_t;

  vec_t vecs[7];

  // Pulse START, follow the run, check latency, A-bus stepping and results
  task automatic do_run(input logic [7:0] e_err, input logic [3:0] e_fail, input logic e_pass);
    int n;
    logic bad;
    ifa.START = 1'b1;
    tick();
    ifa.START = 1'b0;
    n = 0;
    bad = 1'b0;
    while (ifa.BUSY && n < 200) begin
      if ({ifa.A3, ifa.A2, ifa.A1} !== 3'(n / 3)) bad = 1'b1;
      tick();
      n++;
    end
    chk("busy_len", n, 24);
    chk("done", ifa.DONE, 1);
    chk("pass", ifa.PASS, e_pass);
    chk("err_cnt", ifa.ERR_CNT, e_err);
    chk("fail_map", ifa.FAIL_MAP, e_fail);
    chk("abus_step", bad, 0);
    chk("abus_hold", {ifa.A3, ifa.A2, ifa.A1}, 3'd7);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    ifa.START = 1'b0;
    ifb.START = 1'b0;
    st0 = '0;
    st1 = '0;

    vecs[0] = '{4'b0000, 4'b0000, 8'd0,  4'b0000, 1'b1};
    vecs[1] = '{4'b0000, 4'b0010, 8'd1,  4'b0010, 1'b0};
    vecs[2] = '{4'b0001, 4'b0000, 8'd7,  4'b0001, 1'b0};
    vecs[3] = '{4'b1000, 4'b0100, 8'd8,  4'b1100, 1'b0};
    vecs[4] = '{4'b1111, 4'b0000, 8'd28, 4'b1111, 1'b0};
    vecs[5] = '{4'b0000, 4'b1111, 8'd4,  4'b1111, 1'b0};
    vecs[6] = '{4'b0000, 4'b0000, 8'd0,  4'b0000, 1'b1};

    // Reset state
    tick();
    tick();
    chk("rst_busy", ifa.BUSY, 0);
    chk("rst_done", ifa.DONE, 0);
    chk("rst_pass", ifa.PASS, 0);
    chk("rst_fail", ifa.FAIL_MAP, 0);
    chk("rst_err", ifa.ERR_CNT, 0);
    chk("rst_abus", {ifa.A3, ifa.A2, ifa.A1}, 0);
    rst = 1'b0;
    tick();

    // Fault-pattern table
    for (int i = 0; i < 7; i++) begin
      st0 = vecs[i].s0;
      st1 = vecs[i].s1;
      do_run(vecs[i].e_err, vecs[i].e_fail, vecs[i].e_pass);
    end

    // Reset in the middle of a run with errors already accumulated
    st0 = 4'b0001;
    st1 = 4'b0000;
    ifa.START = 1'b1;
    tick();
    ifa.START = 1'b0;
    repeat (10) tick();
    chk("mid_err_before_rst", ifa.ERR_CNT, 3);
    chk("mid_busy_before_rst", ifa.BUSY, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", ifa.BUSY, 0);
    chk("mid_rst_done", ifa.DONE, 0);
    chk("mid_rst_err", ifa.ERR_CNT, 0);
    chk("mid_rst_fail", ifa.FAIL_MAP, 0);
    chk("mid_rst_abus", {ifa.A3, ifa.A2, ifa.A1}, 0);
    tick();
    rst = 1'b0;
    st0 = 4'b0000;
    tick();
    do_run(8'd0, 4'b0000, 1'b1);

    // START held high across the whole run: no restart while busy, restart from DONE
    st1 = 4'b0010;
    ifa.START = 1'b1;
    tick();
    n = 0;
    while (ifa.BUSY && n < 200) begin
      tick();
      n++;
    end
    chk("held_busy_len", n, 24);
    chk("held_done", ifa.DONE, 1);
    chk("held_err", ifa.ERR_CNT, 1);
    tick();
    chk("restart_done", ifa.DONE, 0);
    chk("restart_busy", ifa.BUSY, 1);
    chk("restart_err", ifa.ERR_CNT, 0);
    chk("restart_fail", ifa.FAIL_MAP, 0);
    ifa.START = 1'b0;
    n = 0;
    while (!ifa.DONE && n < 200) begin
      tick();
      n++;
    end
    chk("restart_done_final", ifa.DONE, 1);
    chk("restart_err_final", ifa.ERR_CNT, 1);
    chk("restart_fail_final", ifa.FAIL_MAP, 4'b0010);
    st1 = 4'b0000;

    // Narrow error counter saturates; shorter settle window
    ifb.START = 1'b1;
    tick();
    ifb.START = 1'b0;
    n = 0;
    while (ifb.BUSY && n < 200) begin
      tick();
      n++;
    end
    chk("sat_busy_len", n, 16);
    chk("sat_done", ifb.DONE, 1);
    chk("sat_err", ifb.ERR_CNT, 2'd3);
    chk("sat_fail", ifb.FAIL_MAP, 4'b1111);
    chk("sat_pass", ifb.PASS, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
